decode_8b10b: RTL and testbench
===============================

// Module: decode_8b10b
// PURPOSE
// - Receive-side 8b/10b decoder for the aurora lane; counterpart of encode_8b10b.
// - Decodes 10-bit symbols to byte + control flag and tracks running disparity (RD).
// - Flags code and disparity errors.
// - Runs a comma-based lane-sync state machine that feeds the lane/channel init logic.
// PARAMETERS
// - G_OREG        1  1 = extra output register stage (latency 2); 0 = latency 1
// - G_RD_INIT     0  RD after reset: 0 = negative, 1 = positive (same encoding as disp_i/disp_o)
// - G_SYNC_COMMAS 4  consecutive error-free K28.5 commas needed to declare sync (range 1..15)
// - G_LOS_ERRS    4  consecutive erroneous symbols in SYNC that drop sync (range 1..15)
// PORTS
// - clk_i         in   1   clock
// - rst_i         in   1   synchronous reset, active-high
// - data_i        in   10  symbol {a,b,c,d,e,i,f,g,h,j}; a = bit 9
// - valid_i       in   1   data_i holds a symbol this cycle
// - data_o        out  8   decoded byte HGF_EDCBA; H = bit 7
// - ctrl_o        out  1   symbol was a K code
// - valid_o       out  1   outputs valid; valid_i delayed by the latency
// - code_err_o    out  1   symbol not in 8b/10b table
// - disp_err_o    out  1   symbol disparity violates current RD
// - comma_o       out  1   symbol is K28.5 (0011111010 / 1100000101)
// - disp_o        out  1   RD after this symbol; 0 = negative
// - sync_o        out  1   FSM is in S_SYNC
// BEHAVIOUR
// - Reset: all outputs 0, except disp_o = G_RD_INIT; RD = G_RD_INIT; FSM = S_LOS; counters = 0.
// - Latency: valid_i to valid_o is 1 cycle + G_OREG.
// - Symbols with valid_i = 0 are ignored:
//   - RD, FSM and counters hold.
//   - valid_o = 0; the other outputs hold their last values.
// - Decode: 5b/6b and 3b/4b lookup, both RD columns accepted.
//   - D.x.A7 and K28.x / K23/27/29/30.7 handled per standard table.
//   - ctrl_o = 1 only for the 12 legal K codes.
// - code_err_o:
//   - Sub-block not in table, or sub-block disparity other than 0/±2.
//   - Illegal 6b/4b pairing, e.g. P7 used where A7 is required, or a K-only 4b without a K 6b.
// - Code-error output: data_o = 8'h00, ctrl_o = 0.
// - disp_err_o: a ±2 sub-block whose sign equals the RD at its start.
//   - 6b sub-block checked against the current RD.
//   - 4b sub-block checked against the RD after the 6b sub-block.
//   - 000111 / 111000 are treated as neutral; they flip neither RD nor check.
// - RD update: always taken from the received sub-blocks, even on a disparity error (resyncs RD).
//   - A symbol with a code error leaves RD unchanged.
// - FSM, evaluated on valid symbols only:
//   - S_LOS:
//     - K28.5 -> S_ACQ, comma_cnt = 1.
//     - RD forced to the value that follows that comma (0011111010 -> RD = 1; 1100000101 -> RD = 0).
//       This overrides disp_err.
//   - S_ACQ:
//     - Any code_err or disp_err -> S_LOS.
//     - K28.5 -> comma_cnt + 1. At G_SYNC_COMMAS -> S_SYNC; sync_o rises with that comma's valid_o.
//     - Error-free non-comma symbols hold comma_cnt.
//   - S_SYNC:
//     - Error symbol -> err_cnt + 1. Error-free symbol -> err_cnt = 0.
//     - err_cnt reaches G_LOS_ERRS -> S_LOS; sync_o falls with that symbol's valid_o.
// - sync_o is registered with the data path, so it stays aligned to valid_o.
// - Reset asserted mid-stream: the pipeline flushes (valid_o = 0 the next cycle) and all state returns to reset values.
// CONFIGURATION
// - Macro AURORA_DEC_ERRCNT_EN adds:
//   - err_cnt_clr_i  in   1   clears the counter.
//   - err_cnt_o      out  16  saturating count of valid symbols with code_err or disp_err.
//     - Saturates at 16'hFFFF.
//     - Clear has priority over an increment in the same cycle.
//     - Reset value 0.
// - Without the macro: neither port exists and no counter logic is built.
// TESTING
// - Reset, G_RD_INIT = 0 -> all outputs 0, disp_o = 0, sync_o = 0.
// - Sync (G_SYNC_COMMAS = 4):
//   - Stimulus: 0011111010, 1100000101, 0011111010, 1100000101.
//   - Expect comma_o = 1 and ctrl_o = 1, data_o = 8'hBC on each symbol.
//   - Expect sync_o = 1 with the 4th valid_o and disp_o = 0.
// - Data/control decode, starting at RD- in SYNC:
//   - 1100101110 -> data_o = 8'hF3, ctrl_o = 0, disp_o = 1, no errors.
//   - Then 1000010111 -> data_o = 8'hFE, ctrl_o = 1, disp_o = 1.
// - Disparity error:
//   - At RD- send 1100100001 -> data_o = 8'hF3, disp_err_o = 1, code_err_o = 0, disp_o = 0.
// - Code error and loss of sync:
//   - In SYNC, 4 x 0000000000 -> code_err_o = 1, data_o = 8'h00 each; sync_o falls with the 4th.
//   - Following 1100000101 -> FSM in S_ACQ, sync_o still 0.
// - valid_i gaps:
//   - Alternate valid_i 1/0 over the sync sequence -> same result as back-to-back.
//   - valid_o pattern equals valid_i delayed by the latency.
// - With AURORA_DEC_ERRCNT_EN:
//   - 3 error symbols -> err_cnt_o = 3.
//   - err_cnt_clr_i together with an error symbol -> 0.
//   - Counter forced to 16'hFFFF plus one error -> stays 16'hFFFF.

Source files
------------

// File: rtl/decode_8b10b.sv
// Receive-side 8b/10b decoder with running-disparity tracking and comma-based lane sync.
// Optional saturating symbol-error counter is built when AURORA_DEC_ERRCNT_EN is defined.
module decode_8b10b #(
    parameter int G_OREG        = 1,
    parameter bit G_RD_INIT     = 1'b0,
    parameter int G_SYNC_COMMAS = 4,
    parameter int G_LOS_ERRS    = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [9:0] data_i,
    input  logic       valid_i,
`ifdef AURORA_DEC_ERRCNT_EN
    input  logic        err_cnt_clr_i,
    output logic [15:0] err_cnt_o,
`endif
    output logic [7:0] data_o,
    output logic       ctrl_o,
    output logic       valid_o,
    output logic       code_err_o,
    output logic       disp_err_o,
    output logic       comma_o,
    output logic       disp_o,
    output logic       sync_o
);

    localparam logic [1:0] S_LOS  = 2'd0;
    localparam logic [1:0] S_ACQ  = 2'd1;
    localparam logic [1:0] S_SYNC = 2'd2;

    localparam logic [3:0] SYNC_N = 4'(G_SYNC_COMMAS);
    localparam logic [3:0] LOS_N  = 4'(G_LOS_ERRS);

    logic [5:0] sb6;
    logic [3:0] sb4;
    logic [3:0] sb4_eff;
    logic       v6, v4, k28, a7, p7;
    logic [4:0] x5;
    logic [2:0] y3;
    logic [2:0] ones6, ones4;
    logic       pos6, neg6, pos4, neg4;
    logic       k28_ok, d_a7, k_a7, p7_bad;
    logic       code_err, disp_err, sym_err, ctrl, comma;
    logic [7:0] byte_dec;
    logic       rd_q, rd_d, rd_mid, rd_new, err6, err4;
    logic [1:0] state_q, state_d;
    logic [3:0] comma_cnt_q, comma_cnt_d;
    logic [3:0] err_cnt_q, err_cnt_d;

    logic       v1_q, ctrl1_q, cerr1_q, derr1_q, comma1_q, disp1_q, sync1_q;
    logic [7:0] data1_q;

    assign sb6 = data_i[9:4];
    assign sb4 = data_i[3:0];
    assign k28 = (sb6 == 6'b001111) || (sb6 == 6'b110000);
    // K28 at RD+ is the bitwise complement of K28 at RD-, so decode its 4b inverted.
    assign sb4_eff = (sb6 == 6'b110000) ? ~sb4 : sb4;

    always_comb begin
        v6 = 1'b1;
        x5 = 5'd0;
        case (sb6)
            6'b100111, 6'b011000: x5 = 5'd0;
            6'b011101, 6'b100010: x5 = 5'd1;
            6'b101101, 6'b010010: x5 = 5'd2;
            6'b110001:            x5 = 5'd3;
            6'b110101, 6'b001010: x5 = 5'd4;
            6'b101001:            x5 = 5'd5;
            6'b011001:            x5 = 5'd6;
            6'b111000, 6'b000111: x5 = 5'd7;
            6'b111001, 6'b000110: x5 = 5'd8;
            6'b100101:            x5 = 5'd9;
            6'b010101:            x5 = 5'd10;
            6'b110100:            x5 = 5'd11;
            6'b001101:            x5 = 5'd12;
            6'b101100:            x5 = 5'd13;
            6'b011100:            x5 = 5'd14;
            6'b010111, 6'b101000: x5 = 5'd15;
            6'b011011, 6'b100100: x5 = 5'd16;
            6'b100011:            x5 = 5'd17;
            6'b010011:            x5 = 5'd18;
            6'b110010:            x5 = 5'd19;
            6'b001011:            x5 = 5'd20;
            6'b101010:            x5 = 5'd21;
            6'b011010:            x5 = 5'd22;
            6'b111010, 6'b000101: x5 = 5'd23;
            6'b110011, 6'b001100: x5 = 5'd24;
            6'b100110:            x5 = 5'd25;
            6'b010110:            x5 = 5'd26;
            6'b110110, 6'b001001: x5 = 5'd27;
            6'b001110, 6'b001111, 6'b110000: x5 = 5'd28;
            6'b101110, 6'b010001: x5 = 5'd29;
            6'b011110, 6'b100001: x5 = 5'd30;
            6'b101011, 6'b010100: x5 = 5'd31;
            default:              v6 = 1'b0;
        endcase
    end

    always_comb begin
        v4 = 1'b1;
        y3 = 3'd0;
        a7 = 1'b0;
        p7 = 1'b0;
        case (sb4_eff)
            4'b1011, 4'b0100: y3 = 3'd0;
            4'b1001:          y3 = 3'd1;
            4'b0101:          y3 = 3'd2;
            4'b1100, 4'b0011: y3 = 3'd3;
            4'b1101, 4'b0010: y3 = 3'd4;
            4'b1010:          y3 = 3'd5;
            4'b0110:          y3 = 3'd6;
            4'b1110, 4'b0001: begin y3 = 3'd7; p7 = 1'b1; end
            4'b0111, 4'b1000: begin y3 = 3'd7; a7 = 1'b1; end
            default:          v4 = 1'b0;
        endcase
    end

    always_comb begin
        ones6 = 3'(sb6[0]) + 3'(sb6[1]) + 3'(sb6[2]) + 3'(sb6[3]) + 3'(sb6[4]) + 3'(sb6[5]);
        ones4 = 3'(sb4[0]) + 3'(sb4[1]) + 3'(sb4[2]) + 3'(sb4[3]);
    end

    assign pos6 = (ones6 == 3'd4);
    assign neg6 = (ones6 == 3'd2);
    assign pos4 = (ones4 == 3'd3);
    assign neg4 = (ones4 == 3'd1);

    // Pairing rules: K28 needs its own 4b column, A7 only after specific 6b, P7 never
    // where it would create a run of five.
    always_comb begin
        k28_ok = 1'b0;
        case (sb4_eff)
            4'b0100, 4'b1001, 4'b0101, 4'b0011,
            4'b0010, 4'b1010, 4'b0110, 4'b1000: k28_ok = 1'b1;
            default:                            k28_ok = 1'b0;
        endcase
        d_a7 = 1'b0;
        k_a7 = 1'b0;
        if (sb4 == 4'b0111) begin
            d_a7 = (sb6 == 6'b100011) || (sb6 == 6'b010011) || (sb6 == 6'b001011);
            k_a7 = (sb6 == 6'b000101) || (sb6 == 6'b001001) ||
                   (sb6 == 6'b010001) || (sb6 == 6'b100001);
        end else if (sb4 == 4'b1000) begin
            d_a7 = (sb6 == 6'b110100) || (sb6 == 6'b101100) || (sb6 == 6'b011100);
            k_a7 = (sb6 == 6'b111010) || (sb6 == 6'b110110) ||
                   (sb6 == 6'b101110) || (sb6 == 6'b011110);
        end
        p7_bad = ((sb4 == 4'b1110) && (sb6[1:0] == 2'b11)) ||
                 ((sb4 == 4'b0001) && (sb6[1:0] == 2'b00));
        code_err = !v6 || !v4 ||
                   (k28 ? !k28_ok : ((a7 && !d_a7 && !k_a7) || p7_bad));
    end

    assign ctrl     = !code_err && (k28 || (a7 && k_a7));
    assign byte_dec = code_err ? 8'h00 : {y3, x5};
    assign comma    = (data_i == 10'b0011111010) || (data_i == 10'b1100000101);

    always_comb begin
        err6     = (pos6 && rd_q) || (neg6 && !rd_q);
        rd_mid   = pos6 ? 1'b1 : (neg6 ? 1'b0 : rd_q);
        err4     = (pos4 && rd_mid) || (neg4 && !rd_mid);
        rd_new   = pos4 ? 1'b1 : (neg4 ? 1'b0 : rd_mid);
        disp_err = !code_err && (err6 || err4);
        rd_d     = code_err ? rd_q : rd_new;
        if ((state_q == S_LOS) && comma) begin
            rd_d = ~sb6[5];
        end
    end

    assign sym_err = code_err || disp_err;

    always_comb begin
        state_d     = state_q;
        comma_cnt_d = comma_cnt_q;
        err_cnt_d   = err_cnt_q;
        case (state_q)
            S_LOS: begin
                if (comma) begin
                    comma_cnt_d = 4'd1;
                    err_cnt_d   = 4'd0;
                    state_d     = (SYNC_N <= 4'd1) ? S_SYNC : S_ACQ;
                end
            end
            S_ACQ: begin
                if (sym_err) begin
                    state_d     = S_LOS;
                    comma_cnt_d = 4'd0;
                end else if (comma) begin
                    comma_cnt_d = comma_cnt_q + 4'd1;
                    if (comma_cnt_q + 4'd1 >= SYNC_N) begin
                        state_d   = S_SYNC;
                        err_cnt_d = 4'd0;
                    end
                end
            end
            S_SYNC: begin
                if (sym_err) begin
                    err_cnt_d = err_cnt_q + 4'd1;
                    if (err_cnt_q + 4'd1 >= LOS_N) begin
                        state_d     = S_LOS;
                        err_cnt_d   = 4'd0;
                        comma_cnt_d = 4'd0;
                    end
                end else begin
                    err_cnt_d = 4'd0;
                end
            end
            default: begin
                state_d     = S_LOS;
                comma_cnt_d = 4'd0;
                err_cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_q        <= G_RD_INIT;
            state_q     <= S_LOS;
            comma_cnt_q <= 4'd0;
            err_cnt_q   <= 4'd0;
            v1_q        <= 1'b0;
            data1_q     <= 8'h00;
            ctrl1_q     <= 1'b0;
            cerr1_q     <= 1'b0;
            derr1_q     <= 1'b0;
            comma1_q    <= 1'b0;
            disp1_q     <= G_RD_INIT;
            sync1_q     <= 1'b0;
        end else begin
            v1_q <= valid_i;
            if (valid_i) begin
                rd_q        <= rd_d;
                state_q     <= state_d;
                comma_cnt_q <= comma_cnt_d;
                err_cnt_q   <= err_cnt_d;
                data1_q     <= byte_dec;
                ctrl1_q     <= ctrl;
                cerr1_q     <= code_err;
                derr1_q     <= disp_err;
                comma1_q    <= comma;
                disp1_q     <= rd_d;
                sync1_q     <= (state_d == S_SYNC);
            end
        end
    end

    if (G_OREG != 0) begin : g_oreg
        logic       v2_q, ctrl2_q, cerr2_q, derr2_q, comma2_q, disp2_q, sync2_q;
        logic [7:0] data2_q;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                v2_q     <= 1'b0;
                data2_q  <= 8'h00;
                ctrl2_q  <= 1'b0;
                cerr2_q  <= 1'b0;
                derr2_q  <= 1'b0;
                comma2_q <= 1'b0;
                disp2_q  <= G_RD_INIT;
                sync2_q  <= 1'b0;
            end else begin
                v2_q <= v1_q;
                if (v1_q) begin
                    data2_q  <= data1_q;
                    ctrl2_q  <= ctrl1_q;
                    cerr2_q  <= cerr1_q;
                    derr2_q  <= derr1_q;
                    comma2_q <= comma1_q;
                    disp2_q  <= disp1_q;
                    sync2_q  <= sync1_q;
                end
            end
        end

        assign valid_o    = v2_q;
        assign data_o     = data2_q;
        assign ctrl_o     = ctrl2_q;
        assign code_err_o = cerr2_q;
        assign disp_err_o = derr2_q;
        assign comma_o    = comma2_q;
        assign disp_o     = disp2_q;
        assign sync_o     = sync2_q;
    end else begin : g_no_oreg
        assign valid_o    = v1_q;
        assign data_o     = data1_q;
        assign ctrl_o     = ctrl1_q;
        assign code_err_o = cerr1_q;
        assign disp_err_o = derr1_q;
        assign comma_o    = comma1_q;
        assign disp_o     = disp1_q;
        assign sync_o     = sync1_q;
    end

`ifdef AURORA_DEC_ERRCNT_EN
    logic [15:0] sym_err_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || err_cnt_clr_i) begin
            sym_err_cnt_q <= 16'h0000;
        end else if (valid_i && sym_err && (sym_err_cnt_q != 16'hFFFF)) begin
            sym_err_cnt_q <= sym_err_cnt_q + 16'h0001;
        end
    end

    assign err_cnt_o = sym_err_cnt_q;
`endif

endmodule

// File: tb/tb_decode_8b10b.sv
// Scoreboard bench for decode_8b10b: directed symbols push expected outputs, a monitor pops
// and compares on every valid_o. Error-counter checks run when AURORA_DEC_ERRCNT_EN is set.
module tb_decode_8b10b;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic [9:0] data_i = 10'd0;
    logic       valid_i = 1'b0;
    logic [7:0] data_o;
    logic       ctrl_o, valid_o, code_err_o, disp_err_o, comma_o, disp_o, sync_o;
`ifdef AURORA_DEC_ERRCNT_EN
    logic        err_cnt_clr_i = 1'b0;
    logic [15:0] err_cnt_o;
`endif

    typedef struct packed {
        logic [7:0] data;
        logic       ctrl;
        logic       cerr;
        logic       derr;
        logic       comma;
        logic       disp;
        logic       sync;
    } exp_t;

    exp_t       exp_q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         n_out = 0;
    logic [1:0] vhist;

    decode_8b10b #(
        .G_OREG       (1),
        .G_RD_INIT    (1'b0),
        .G_SYNC_COMMAS(4),
        .G_LOS_ERRS   (4)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .data_i       (data_i),
        .valid_i      (valid_i),
`ifdef AURORA_DEC_ERRCNT_EN
        .err_cnt_clr_i(err_cnt_clr_i),
        .err_cnt_o    (err_cnt_o),
`endif
        .data_o       (data_o),
        .ctrl_o       (ctrl_o),
        .valid_o      (valid_o),
        .code_err_o   (code_err_o),
        .disp_err_o   (disp_err_o),
        .comma_o      (comma_o),
        .disp_o       (disp_o),
        .sync_o       (sync_o)
    );

    always #5 clk = ~clk;

    // Reference for valid_o: valid_i delayed by two cycles, flushed by reset.
    always @(posedge clk) begin
        if (rst_i) vhist <= 2'b00;
        else       vhist <= {vhist[0], valid_i};
    end

    always @(negedge clk) begin
        exp_t act, e;
        if (!rst_i) begin
            n_cmp++;
            if (valid_o !== vhist[1]) begin
                n_err++;
                $display("FAIL valid_pattern @%0t: got %b want %b", $time, valid_o, vhist[1]);
            end
            if (valid_o === 1'b1) begin
                act = {data_o, ctrl_o, code_err_o, disp_err_o, comma_o, disp_o, sync_o};
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL out%0d unexpected: got %h want nothing", n_out, act);
                end else begin
                    e = exp_q.pop_front();
                    if (act !== e) begin
                        n_err++;
                        $display("FAIL out%0d: got data=%h k=%b ce=%b de=%b cm=%b rd=%b sy=%b want data=%h k=%b ce=%b de=%b cm=%b rd=%b sy=%b",
                                 n_out, act.data, act.ctrl, act.cerr, act.derr, act.comma,
                                 act.disp, act.sync, e.data, e.ctrl, e.cerr, e.derr, e.comma,
                                 e.disp, e.sync);
                    end
                end
                n_out++;
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, expv);
        end
    endtask

    task automatic send(input logic [9:0] sym, input logic [7:0] b, input logic k,
                        input logic ce, input logic de, input logic cm, input logic dp,
                        input logic sy);
        @(posedge clk);
        #1;
        data_i  = sym;
        valid_i = 1'b1;
        exp_q.push_back({b, k, ce, de, cm, dp, sy});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            valid_i = 1'b0;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        chk("reset_outs", {1'b0, valid_o, data_o, ctrl_o, code_err_o, disp_err_o, comma_o,
                           disp_o, sync_o}, 16'h0000);

        // Lane sync: four alternating K28.5 commas.
        send(10'b0011111010, 8'hBC, 1, 0, 0, 1, 1, 0);
        send(10'b1100000101, 8'hBC, 1, 0, 0, 1, 0, 0);
        send(10'b0011111010, 8'hBC, 1, 0, 0, 1, 1, 0);
        send(10'b1100000101, 8'hBC, 1, 0, 0, 1, 0, 1);
        // D19.7 then K30.7
        send(10'b1100101110, 8'hF3, 0, 0, 0, 0, 1, 1);
        send(10'b1000010111, 8'hFE, 1, 0, 0, 0, 1, 1);
        // Back to RD-, then disparity error on the 4b sub-block.
        send(10'b1100000101, 8'hBC, 1, 0, 0, 1, 0, 1);
        send(10'b1100100001, 8'hF3, 0, 0, 1, 0, 0, 1);
        send(10'b0011111010, 8'hBC, 1, 0, 0, 1, 1, 1);
        // Four code errors drop sync on the fourth.
        send(10'b0000000000, 8'h00, 0, 1, 0, 0, 1, 1);
        send(10'b0000000000, 8'h00, 0, 1, 0, 0, 1, 1);
        send(10'b0000000000, 8'h00, 0, 1, 0, 0, 1, 1);
        send(10'b0000000000, 8'h00, 0, 1, 0, 0, 1, 0);
        send(10'b1100000101, 8'hBC, 1, 0, 0, 1, 0, 0);
        // P7 where A7 is required; K-only 4b after a D 6b; legal D17.A7.
        send(10'b1000111110, 8'h00, 0, 1, 0, 0, 0, 0);
        send(10'b1100010111, 8'h00, 0, 1, 0, 0, 0, 0);
        send(10'b1000110111, 8'hF1, 0, 0, 0, 0, 1, 0);
        // Comma in LOS with wrong disparity still acquires.
        send(10'b0011111010, 8'hBC, 1, 0, 1, 1, 1, 0);
        send(10'b1100000101, 8'hBC, 1, 0, 0, 1, 0, 0);
        idle(3);

        // Mid-stream reset with one symbol in flight (no output expected from it).
        @(posedge clk);
        #1;
        data_i  = 10'b0011111010;
        valid_i = 1'b1;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        rst_i   = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        chk("post_reset", {13'd0, valid_o, disp_o, sync_o}, 16'h0000);

        // Sync sequence with valid_i gaps.
        send(10'b0011111010, 8'hBC, 1, 0, 0, 1, 1, 0);
        idle(1);
        send(10'b1100000101, 8'hBC, 1, 0, 0, 1, 0, 0);
        idle(1);
        send(10'b0011111010, 8'hBC, 1, 0, 0, 1, 1, 0);
        idle(1);
        send(10'b1100000101, 8'hBC, 1, 0, 0, 1, 0, 1);
        idle(4);
        @(negedge clk);
        chk("hold_outs", {6'd0, valid_o, data_o, sync_o}, {6'd0, 1'b0, 8'hBC, 1'b1});

`ifdef AURORA_DEC_ERRCNT_EN
        send(10'b0000000000, 8'h00, 0, 1, 0, 0, 0, 1);
        send(10'b0000000000, 8'h00, 0, 1, 0, 0, 0, 1);
        send(10'b0000000000, 8'h00, 0, 1, 0, 0, 0, 1);
        idle(1);
        @(negedge clk);
        chk("err_cnt_3", err_cnt_o, 16'd3);
        send(10'b0000000000, 8'h00, 0, 1, 0, 0, 0, 0);
        err_cnt_clr_i = 1'b1;
        idle(1);
        err_cnt_clr_i = 1'b0;
        @(negedge clk);
        chk("err_cnt_clr", err_cnt_o, 16'd0);
        for (int i = 0; i < 65535; i++) begin
            send(10'b0000000000, 8'h00, 0, 1, 0, 0, 0, 0);
        end
        idle(1);
        @(negedge clk);
        chk("err_cnt_max", err_cnt_o, 16'hFFFF);
        send(10'b0000000000, 8'h00, 0, 1, 0, 0, 0, 0);
        idle(1);
        @(negedge clk);
        chk("err_cnt_sat", err_cnt_o, 16'hFFFF);
`endif

        idle(1);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        chk("queue_empty", 16'(exp_q.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
